// File: rtl/cla_pipe_adder.sv
// Carry-pipelined hierarchical CLA adder/subtractor with valid/ready handshakes.
// Each 16-bit section (4x4-bit groups plus a lookahead unit) resolves in its own stage.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSEC = WIDTH / 16;

  // Group generate; p holds propagate bits 3:1 of the group.
  function automatic logic grp_g(input logic [3:0] g, input logic [2:0] p);
    return g[3] | (p[2] & g[2]) | (p[2] & p[1] & g[1]) | (p[2] & p[1] & p[0] & g[0]);
  endfunction

  // Carries into each bit of a 4-bit group from the group carry-in.
  function automatic logic [3:0] grp_c(input logic [2:0] g, input logic [2:0] p, input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // One 16-bit section: returns {c16, c15, sum[15:0]}.
  function automatic logic [17:0] sec_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gs;
    logic [3:0]  ps;
    logic [4:0]  cg;
    p = x ^ y;
    g = x & y;
    for (int i = 0; i < 4; i++) begin
      gs[i] = grp_g(g[4*i +: 4], p[4*i+1 +: 3]);
      ps[i] = &p[4*i +: 4];
    end
    cg[0] = ci;
    cg[1] = gs[0] | (ps[0] & ci);
    cg[2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & ci);
    cg[3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0]) | (ps[2] & ps[1] & ps[0] & ci);
    cg[4] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1]) | (ps[3] & ps[2] & ps[1] & gs[0])
          | (&ps & ci);
    for (int i = 0; i < 4; i++) begin
      c[4*i +: 4] = grp_c(g[4*i +: 3], p[4*i +: 3], cg[i]);
    end
    return {cg[4], c[15], p ^ c};
  endfunction

  logic             stall;
  logic             cin;
  logic [WIDTH-1:0] bx;
  logic [NSEC-1:0]  valid_q;
  logic [NSEC-1:0]  carry_q;
  logic [NSEC-1:0]  zero_q;
  logic             ovf_q;
  logic [NSEC-1:0]  ld;
  logic [NSEC:0]    vch;
  logic [NSEC:0]    cch;
  logic [NSEC:0]    zch;
  logic [17:0]      sec_r [NSEC];

  // Stage chains: index s is what stage s consumes, index NSEC is the output stage.
  always_comb begin
    vch      = {valid_q, in_valid};
    cch      = {carry_q, cin};
    zch      = {zero_q, 1'b1};
    stall    = vch[NSEC] & ~out_ready;
    in_ready = ~stall;
    bx       = sub ? ~b : b;
    cin      = sub ^ c0;
    ld       = '0;
    for (int s = 0; s < NSEC; s++) begin
      ld[s] = ~stall & vch[s];
    end
  end

  // Per-stage valid, section carry and accumulated zero; data only loads with a live beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      zero_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= vch[NSEC-1:0];
      for (int s = 0; s < NSEC; s++) begin
        if (vch[s]) begin
          carry_q[s] <= sec_r[s][17];
          zero_q[s]  <= zch[s] & (sec_r[s][15:0] == 16'd0);
        end
      end
      if (vch[NSEC-1]) ovf_q <= sec_r[NSEC-1][17] ^ sec_r[NSEC-1][16];
    end
  end

  for (genvar j = 0; j < NSEC; j++) begin : g_sec
    localparam int unsigned L = NSEC - j;
    logic [15:0] sa;
    logic [15:0] sb;
    logic [15:0] r_sk [L];

    if (j == 0) begin : g_head
      assign sa = a[15:0];
      assign sb = bx[15:0];
    end else begin : g_skew
      // Input skew: section j operands wait j stages for their carry.
      logic [15:0] a_sk [j];
      logic [15:0] b_sk [j];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < j; i++) begin
            a_sk[i] <= '0;
            b_sk[i] <= '0;
          end
        end else begin
          if (ld[0]) begin
            a_sk[0] <= a[j*16 +: 16];
            b_sk[0] <= bx[j*16 +: 16];
          end
          for (int i = 1; i < j; i++) begin
            if (ld[i]) begin
              a_sk[i] <= a_sk[i-1];
              b_sk[i] <= b_sk[i-1];
            end
          end
        end
      end
      assign sa = a_sk[j-1];
      assign sb = b_sk[j-1];
    end

    assign sec_r[j] = sec_add(sa, sb, cch[j]);

    // Output deskew so every section of a result leaves in the same cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < L; i++) r_sk[i] <= '0;
      end else begin
        if (ld[j]) r_sk[0] <= sec_r[j][15:0];
        for (int i = 1; i < L; i++) begin
          if (ld[j+i]) r_sk[i] <= r_sk[i-1];
        end
      end
    end

    assign sum[j*16 +: 16] = r_sk[L-1];
  end

  assign out_valid = vch[NSEC];
  assign cout      = cch[NSEC];
  assign zero      = zch[NSEC];
  assign ovf       = ovf_q;

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, carry-pipelined hierarchical carry-lookahead adder/subtractor with valid/ready handshakes. Operands are split into 16-bit sections, each built as four 4-bit CLA groups with a second-level lookahead unit. One section is resolved per pipeline stage, and the carry is registered between stages. Sustained throughput is one operation per clock. The block sits between an operand producer and a result consumer in the datapath, as the wide successor to the single-cycle 16-bit CLA.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 16 (16..128).
- NSEC, WIDTH/16, derived (localparam): section count, equal to the pipeline depth.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B+c0; 1 = A−B−c0 (c0 acts as borrow-in).
- c0  in  1  carry-in (add) / borrow-in (sub).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- Input transform:
  - B' = sub ? ~b : b.
  - Carry-in cin = sub ? ~c0 : c0.
- Section k (bits 16k+15:16k):
  - 4-bit groups compute per-bit p = a^B' and g = a&B'.
  - Each group produces group generate/propagate (gs, ps).
  - A second-level lookahead unit produces internal carries c4, c8, c12 and section carry-out c16 from the section's carry-in.
  - Section sum = p ^ carries.
- Pipeline:
  - Stage k resolves section k using the carry registered by stage k−1. Stage 0 uses cin.
  - Operand bits for section k are delayed k stages (input skew).
  - Result bits of section k are delayed NSEC−1−k stages (output deskew), so all bits of a result leave together.
- Flags, computed from the final section:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = AND of per-section zero bits, accumulated through the pipeline.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. This is a combinational path from out_ready.
  - A beat is accepted when in_valid & in_ready.
  - While stall=1, every stage register, including the valid bits, holds its value.
  - Each stage carries a valid bit. Bubbles propagate as valid=0 and never produce output.
- Ordering: results emerge in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N presents out_valid=1 with its result after edge N+NSEC−1, i.e. during cycle N+NSEC. With no stalls this equals NSEC cycles (2 for WIDTH=32).
- Throughput: 1 beat per cycle when out_ready is held high.
- Reset:
  - rst=1 at an edge clears all stage valid bits.
  - From the next cycle, out_valid=0 and sum, cout, ovf and zero are 0.
  - in_ready follows ~stall, so it is 1 after reset.
- Reset mid-operation discards all in-flight beats. No result from before reset ever appears.
- rst takes priority over stall and over acceptance in the same cycle.
- Simultaneous events:
  - Accept and emit in the same cycle is legal with no stall.
  - out_ready=1 while out_valid=0 has no effect.
- Data outputs are registered. When out_valid=0 their value is don't-care, except after reset.
- Wrap-around: sum is modulo 2^WIDTH, and carry and overflow are reported only through cout and ovf.

## Test plan
- Section-boundary carry: WIDTH=32, a=0x0000FFFF, b=0x00000001, sub=0, c0=0 -> sum=0x00010000, cout=0, ovf=0, zero=0, out_valid exactly 2 cycles after acceptance.
- Full wrap: a=0xFFFFFFFF, b=0x00000001, c0=0 -> sum=0x00000000, cout=1, ovf=0, zero=1.
- Signed overflow and carry-in:
  - a=0x7FFFFFFF, b=0, c0=1 -> sum=0x80000000, ovf=1, cout=0.
  - a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1, zero=1.
- Subtract with borrow:
  - sub=1, a=5, b=7, c0=0 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - sub=1, a=7, b=5, c0=1 -> sum=0x00000001, cout=1.
- Backpressure streaming: 6 back-to-back beats (a=i, b=0x1000·i), out_ready low for 3 cycles after the 2nd result -> in_ready low exactly while stalled, all 6 results correct, in order, each seen once; random 1000-beat run with random out_ready checked against a reference model (WIDTH=16, 32, 64).
- Reset mid-flight: accept 2 beats, assert rst one cycle -> out_valid=0 the next cycle, neither pre-reset result ever appears, and a beat accepted after reset returns its correct result with normal latency.
